ramreader: RTL and testbench

Streams 16-bit signed samples out of the 64-bit sample RAM, reading one word per address in ascending order and serialising each word into four samples. It is the read-side counterpart of the RAM write path: it drives the RAM read port (address, read enable) and presents samples on a valid/ready stream for downstream consumers (DAC feed, UART dump). Read latency is absorbed by a 2-entry word buffer, so the output sustains one sample per clock under continuous `i_ready`.

---
 rtl/ramreader.sv | 233 +++++++++++++++++++++++
 tb/tb_ramreader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramreader.sv
// ramreader: streams 16-bit samples out of the 64-bit sample RAM.
// One RAM word is read per address in ascending order (wrapping at DEPTH)
// and each word is serialised MSB-first into four samples on a valid/ready
// stream. RAM read latency is absorbed by a 2-entry word FIFO.
//
// Optional feature macro: RAMREADER_CHECK_EN
//   defined   -> sequence checker: o_err is set (sticky) when an accepted
//                sample is not the previous accepted sample + 1.
//   undefined -> no checker, o_err tied to 0.
//
// Fetch FSM
//   state   | meaning
//   F_IDLE  | not fetching, pipeline empty
//   F_RUN   | fetching: a read is issued whenever credit allows
//   F_DRAIN | no new reads; in-flight/buffered words still flow out
//
// Serialiser FSM
//   state   | meaning
//   S_EMPTY | no word loaded, o_valid low
//   S_0     | presenting bits [63:48]
//   S_1     | presenting bits [47:32]
//   S_2     | presenting bits [31:16]
//   S_3     | presenting bits [15:0]

`timescale 1ns/1ps

module ramreader #(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_rden,
    input  logic [63:0]       i_q,
    output logic [15:0]       o_sample,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_err
);

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_RUN   = 2'd1,
        F_DRAIN = 2'd2
    } fetch_t;

    typedef enum logic [2:0] {
        S_EMPTY = 3'd0,
        S_0     = 3'd1,
        S_1     = 3'd2,
        S_2     = 3'd3,
        S_3     = 3'd4
    } ser_t;

    fetch_t            fetch_state;
    fetch_t            fetch_next;
    ser_t              ser_state;
    ser_t              ser_next;

    logic [ADDR_W-1:0] addr_next;
    logic [RD_LAT-1:0] rd_pipe;
    logic [1:0]        inflight;
    logic [1:0]        fifo_cnt;
    logic              fifo_wr_ptr;
    logic              fifo_rd_ptr;
    logic [63:0]       fifo_mem [2];
    logic [63:0]       ser_word;

    logic              capture;
    logic              pop;
    logic              issue;
    logic              hs;
    logic [2:0]        credit_used;

    // A word returns from the RAM when its read enable reaches the pipe end.
    assign capture = rd_pipe[RD_LAT-1];
    assign hs      = o_valid & i_ready;
    assign o_valid = (ser_state != S_EMPTY);
    assign o_busy  = (inflight != 2'd0) | (fifo_cnt != 2'd0) | (ser_state != S_EMPTY);

    // Credit after this edge: captures move a word from in-flight to the
    // FIFO (net zero), a pop frees one slot. The word being serialised does
    // not hold a credit, so at most two reads run ahead of it.
    assign credit_used = 3'(inflight) + 3'(fifo_cnt) - 3'(pop);

    // Fetch FSM next-state and read-issue decision.
    always_comb begin
        fetch_next = fetch_state;
        case (fetch_state)
            F_IDLE: begin
                if (i_en) fetch_next = F_RUN;
            end
            F_RUN: begin
                if (!i_en) fetch_next = F_DRAIN;
            end
            F_DRAIN: begin
                if (i_en)         fetch_next = F_RUN;
                else if (!o_busy) fetch_next = F_IDLE;
            end
            default: fetch_next = F_IDLE;
        endcase
        issue = (fetch_next == F_RUN) && (credit_used < 3'd2);
    end

    // Fetch state, registered read port and address post-increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_state <= F_IDLE;
            o_rden      <= 1'b0;
            o_address   <= '0;
            addr_next   <= '0;
        end else begin
            fetch_state <= fetch_next;
            o_rden      <= issue;
            if (issue) begin
                o_address <= addr_next;
                if (addr_next == ADDR_W'(DEPTH - 1)) addr_next <= '0;
                else                                 addr_next <= addr_next + 1'b1;
            end
        end
    end

    // Read-latency tracker and in-flight read counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pipe  <= '0;
            inflight <= 2'd0;
        end else begin
            rd_pipe[0] <= o_rden;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            inflight <= inflight + 2'(issue) - 2'(capture);
        end
    end

    // Two-entry word FIFO between the RAM and the serialiser.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (capture) begin
                fifo_mem[fifo_wr_ptr] <= i_q;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(capture) - 2'(pop);
        end
    end

    // Serialiser next-state; S_3 reloads directly from the FIFO so there is
    // no bubble between words.
    always_comb begin
        ser_next = ser_state;
        pop      = 1'b0;
        case (ser_state)
            S_EMPTY: begin
                if (fifo_cnt != 2'd0) begin
                    ser_next = S_0;
                    pop      = 1'b1;
                end
            end
            S_0: if (hs) ser_next = S_1;
            S_1: if (hs) ser_next = S_2;
            S_2: if (hs) ser_next = S_3;
            S_3: begin
                if (hs) begin
                    if (fifo_cnt != 2'd0) begin
                        ser_next = S_0;
                        pop      = 1'b1;
                    end else begin
                        ser_next = S_EMPTY;
                    end
                end
            end
            default: ser_next = S_EMPTY;
        endcase
    end

    // Serialiser state and the word being emitted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ser_state <= S_EMPTY;
            ser_word  <= '0;
        end else begin
            ser_state <= ser_next;
            if (pop) ser_word <= fifo_mem[fifo_rd_ptr];
        end
    end

    // Sample select from the loaded word; zero while empty.
    always_comb begin
        o_sample = 16'h0000;
        case (ser_state)
            S_0:     o_sample = ser_word[63:48];
            S_1:     o_sample = ser_word[47:32];
            S_2:     o_sample = ser_word[31:16];
            S_3:     o_sample = ser_word[15:0];
            default: o_sample = 16'h0000;
        endcase
    end

`ifdef RAMREADER_CHECK_EN
    logic [15:0] prev_sample;
    logic        have_prev;
    logic        err;

    // Sequence checker: every accepted sample after the first must be the
    // previous one plus one (16-bit wrap). Only reset clears the history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_sample <= 16'h0000;
            have_prev   <= 1'b0;
            err         <= 1'b0;
        end else if (hs) begin
            if (have_prev && (o_sample != prev_sample + 16'd1)) err <= 1'b1;
            prev_sample <= o_sample;
            have_prev   <= 1'b1;
        end
    end

    assign o_err = err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_ramreader.sv
// Self-checking bench for ramreader: behavioural RAM, scoreboard of expected
// samples pushed on each issued read, and a negedge monitor that pops and
// compares on every handshake.

`timescale 1ns/1ps

module tb_ramreader;

    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 14;
    localparam int RD_LAT = 2;
`ifdef RAMREADER_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              ready;
    logic [ADDR_W-1:0] address;
    logic              rden;
    logic [63:0]       q;
    logic [15:0]       sample;
    logic              valid;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    ramreader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .o_address (address),
        .o_rden    (rden),
        .i_q       (q),
        .o_sample  (sample),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_busy    (busy),
        .o_err     (err)
    );

    // RAM content: word n holds samples -32768+4n .. -32765+4n; word 5 has a
    // corrupted second sample.
    function automatic logic [63:0] word_fn(input int unsigned a);
        logic [15:0] b;
        logic [63:0] w;
        b = 16'h8000 + 16'(a * 4);
        w = {b, b + 16'd1, b + 16'd2, b + 16'd3};
        if (a == 5) w[47:32] = w[47:32] ^ 16'h0F0F;
        return w;
    endfunction

    // Behavioural RAM with RD_LAT cycles of read latency.
    logic [ADDR_W-1:0] ram_addr [RD_LAT];
    logic              ram_vld  [RD_LAT];
    always @(posedge clk) begin
        ram_addr[0] <= address;
        ram_vld[0]  <= rden;
        for (int i = 1; i < RD_LAT; i++) begin
            ram_addr[i] <= ram_addr[i-1];
            ram_vld[i]  <= ram_vld[i-1];
        end
    end
    assign q = (ram_vld[RD_LAT-1] === 1'b1) ? word_fn(int'(ram_addr[RD_LAT-1])) : 64'hDEAD_BEEF_DEAD_BEEF;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sbq[$];
    int unsigned exp_addr = 0;
    int unsigned reads_since_reset = 0;
    int unsigned rden_total = 0;
    logic [ADDR_W-1:0] addr_at_2049 = '1;
    bit          seen_2049 = 0;
    bit          model_err = 0;
    bit          have_prev = 0;
    logic [15:0] prev_s = 16'h0;
    bit          hold_pend = 0;
    logic [15:0] hold_s = 16'h0;
    logic        en_at_edge = 1'b0;

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] req);
        errors++;
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    always @(posedge clk) en_at_edge <= en;

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (err !== (model_err & CHECK_ON)) fail("err", 64'(err), 64'(model_err & CHECK_ON));
            if (hold_pend) begin
                checks++;
                if (!(valid === 1'b1 && sample === hold_s)) fail("hold", {valid, sample}, {1'b1, hold_s});
                hold_pend = 0;
            end
            if (en_at_edge == 1'b0) begin
                checks++;
                if (rden !== 1'b0) fail("rden_while_disabled", 64'(rden), 64'd0);
            end
            if (rden === 1'b1) begin
                logic [63:0] w;
                checks++;
                if (address !== ADDR_W'(exp_addr)) fail("address", 64'(address), 64'(exp_addr));
                w = word_fn(exp_addr);
                sbq.push_back(w[63:48]);
                sbq.push_back(w[47:32]);
                sbq.push_back(w[31:16]);
                sbq.push_back(w[15:0]);
                exp_addr = (exp_addr + 1) % DEPTH;
                reads_since_reset++;
                rden_total++;
                if (reads_since_reset == 2049) begin
                    addr_at_2049 = address;
                    seen_2049    = 1;
                end
                checks++;
                if (sbq.size() > 12) fail("read_credit", 64'(sbq.size()), 64'd12);
            end
            checks++;
            if (busy !== (sbq.size() != 0)) fail("busy", 64'(busy), 64'(sbq.size() != 0));
            if (valid === 1'b1 && ready === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    fail("unexpected_sample", 64'(sample), 64'd0);
                end else begin
                    logic [15:0] e;
                    e = sbq.pop_front();
                    if (sample !== e) fail("sample", 64'(sample), 64'(e));
                    if (have_prev && (e != prev_s + 16'd1)) model_err = 1;
                    prev_s    = e;
                    have_prev = 1;
                end
            end else if (valid === 1'b1) begin
                hold_pend = 1;
                hold_s    = sample;
            end
        end
    end

    task automatic clear_model();
        sbq.delete();
        exp_addr          = 0;
        reads_since_reset = 0;
        seen_2049         = 0;
        model_err         = 0;
        have_prev         = 0;
        hold_pend         = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({address, rden, sample, valid, busy, err} !== '0)
            fail(tag, 64'({address, rden, sample, valid, busy, err}), 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b0) break;
        end
        checks++;
        if (busy !== 1'b0) fail({tag, "_timeout"}, 64'(busy), 64'd0);
        checks++;
        if (sbq.size() != 0) fail({tag, "_left"}, 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        int k;
        int r0;
        int bubbles;
        rst_n = 1'b0;
        en    = 1'b0;
        ready = 1'b0;
        #2;
        check_reset_outputs("reset_values");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("after_release");

        // First-valid latency from an empty pipeline.
        en    = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); k++; #1;
            if (valid === 1'b1) break;
        end
        checks++;
        if (k != RD_LAT + 2) fail("first_valid_edge", 64'(k), 64'(RD_LAT + 2));
        checks++;
        if (sample !== 16'h8000) fail("first_sample", 64'(sample), 64'h8000);

        // Backpressure while -32766 is presented.
        for (int i = 0; i < 10; i++) begin
            if (valid === 1'b1 && sample === 16'h8002) break;
            @(posedge clk); #1;
        end
        checks++;
        if (!(valid === 1'b1 && sample === 16'h8002)) fail("bp_reach", 64'(sample), 64'h8002);
        ready = 1'b0;
        r0 = int'(rden_total);
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (rden_total - r0 > 2) fail("bp_reads", 64'(rden_total - r0), 64'd2);
        checks++;
        if (sample !== 16'h8002) fail("bp_hold", 64'(sample), 64'h8002);
        ready = 1'b1;

        // Steady state: no bubbles, one read per four clocks.
        repeat (20) @(posedge clk);
        r0 = int'(rden_total);
        bubbles = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid !== 1'b1) bubbles++;
        end
        checks++;
        if (bubbles != 0) fail("steady_bubbles", 64'(bubbles), 64'd0);
        checks++;
        if (rden_total - r0 != 10) fail("steady_reads", 64'(rden_total - r0), 64'd10);

        // Drain after an S1 sample is accepted.
        for (int i = 0; i < 8; i++) begin
            if (valid === 1'b1 && sample[1:0] == 2'd1) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        en = 1'b0;
        wait_idle("drain");
        repeat (5) @(posedge clk);
        #1;
        en = 1'b1;

        // Randomised enable / ready.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) en = ~en;
        end

        // Asynchronous reset in the middle of streaming.
        en    = 1'b1;
        ready = 1'b1;
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        clear_model();
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (address !== '0 || valid !== 1'b0) fail("post_reset", 64'({address, valid}), 64'd0);

        // Address wrap: 2049th read after reset targets address 0.
        for (int i = 0; i < 9500; i++) begin
            @(posedge clk); #1;
            if (seen_2049) break;
        end
        checks++;
        if (!seen_2049) fail("wrap_timeout", 64'(reads_since_reset), 64'd2049);
        else if (addr_at_2049 !== '0) fail("wrap_address", 64'(addr_at_2049), 64'd0);

        en = 1'b0;
        wait_idle("final_drain");
        checks++;
        if (err !== (model_err & CHECK_ON)) fail("final_err", 64'(err), 64'(model_err & CHECK_ON));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
